pipelined_cla_alu: RTL and testbench

- Parametrised, pipelined successor to the two-level carry-lookahead adder.
- WIDTH-bit operands are split into SLICE_WIDTH slices. Each pipeline stage adds one slice with a two-level CLA and registers the inter-slice carry, so a wide add closes timing at board clock rate.
- Adds subtract, accumulate and accumulator-load modes, plus valid/ready handshakes with backpressure on both sides.
- Sits between the board I/O synchronisation registers and the LED/result registers, or feeds any streaming consumer.

---
 rtl/cla_alu_pkg.sv | 24 ++
 rtl/cla_slice.sv | 78 +++++++
 rtl/pipelined_cla_alu.sv | 166 ++++++++++++++++
 tb/tb_pipelined_cla_alu.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_alu_pkg.sv
// Shared definitions for the pipelined carry-lookahead ALU: op codes, stage count, parameter legality.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package cla_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } cla_op_e;

    // Number of pipeline stages: one per slice of the operand.
    function automatic int cla_stages(input int width, input int slice_width);
        return width / slice_width;
    endfunction

    // Slices must tile the word exactly and groups must tile a slice exactly.
    function automatic bit cla_params_ok(input int width, input int slice_width, input int group_width);
        return (width > 0) && (slice_width > 0) && (group_width > 0) &&
               ((width % slice_width) == 0) && ((slice_width % group_width) == 0);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational two-level carry-lookahead adder for one slice, built from GROUP_WIDTH-bit groups.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the enclosing pipeline stage owns flow control.
module cla_slice
    import cla_alu_pkg::*;
#(
    parameter int SLICE_WIDTH = 4,
    parameter int GROUP_WIDTH = 2
) (
    input  logic [SLICE_WIDTH-1:0] i_a,
    input  logic [SLICE_WIDTH-1:0] i_b,
    input  logic                   i_cin,
    output logic [SLICE_WIDTH-1:0] o_sum,
    output logic                   o_cout,
    output logic                   o_cmsb
);
    localparam int NG = SLICE_WIDTH / GROUP_WIDTH;
    localparam int GW = GROUP_WIDTH;

    if (!cla_params_ok(SLICE_WIDTH, SLICE_WIDTH, GROUP_WIDTH)) begin : g_bad_params
        $error("cla_slice: GROUP_WIDTH must divide SLICE_WIDTH");
    end

    // Bit g/p -> group G/P -> lookahead group carries -> bit carries inside each group.
    always_comb begin
        logic [SLICE_WIDTH-1:0] g;
        logic [SLICE_WIDTH-1:0] p;
        logic [NG-1:0]          gg;
        logic [NG-1:0]          gp;
        logic [NG:0]            gc;
        logic [SLICE_WIDTH:0]   c;
        logic                   term;
        logic                   prod;

        g    = i_a & i_b;
        p    = i_a ^ i_b;
        gg   = '0;
        gp   = '0;
        gc   = '0;
        c    = '0;
        term = 1'b0;
        prod = 1'b0;

        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < GW; i++) begin
                gg[j] = g[j*GW+i] | (p[j*GW+i] & gg[j]);
                gp[j] = gp[j] & p[j*GW+i];
            end
        end

        // Second level: each group carry is a flat sum of products, not a ripple.
        gc[0] = i_cin;
        for (int j = 0; j < NG; j++) begin
            term = gg[j];
            prod = gp[j];
            for (int m = j - 1; m >= 0; m--) begin
                term = term | (prod & gg[m]);
                prod = prod & gp[m];
            end
            gc[j+1] = term | (prod & i_cin);
        end

        for (int j = 0; j < NG; j++) begin
            c[j*GW] = gc[j];
            for (int i = 0; i < GW - 1; i++) begin
                c[j*GW+i+1] = g[j*GW+i] | (p[j*GW+i] & c[j*GW+i]);
            end
        end
        c[SLICE_WIDTH] = gc[NG];

        o_sum  = p ^ c[SLICE_WIDTH-1:0];
        o_cout = c[SLICE_WIDTH];
        o_cmsb = c[SLICE_WIDTH-1];
    end

endmodule

// File: rtl/pipelined_cla_alu.sv
// Pipelined CLA ALU (ADD/SUB/ACC/LOAD), one SLICE_WIDTH slice added per stage with registered inter-slice carry.
// Latency: result valid STAGES cycles after accept; one op per cycle when out_ready stays high.
// Backpressure: whole pipeline freezes while out_valid && !out_ready; in_ready mirrors the advance condition.
module pipelined_cla_alu
    import cla_alu_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SLICE_WIDTH = 4,
    parameter int GROUP_WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry_out,
    output logic             overflow
);
    localparam int STAGES = cla_stages(WIDTH, SLICE_WIDTH);
    localparam int SW     = SLICE_WIDTH;

    if (!cla_params_ok(WIDTH, SLICE_WIDTH, GROUP_WIDTH)) begin : g_bad_params
        $error("pipelined_cla_alu: WIDTH must be a multiple of SLICE_WIDTH, SLICE_WIDTH of GROUP_WIDTH");
    end

    // Rank k holds the op about to be processed by stage k. Carrying the whole
    // operand word down the ranks delays slice k by exactly k cycles, and r_sum
    // collects the finished low slices so the result leaves the last stage aligned.
    logic             r_vld [STAGES];
    logic [1:0]       r_op  [STAGES];
    logic [WIDTH-1:0] r_x   [STAGES];
    logic [WIDTH-1:0] r_y   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic [WIDTH-1:0] r_acc;

    logic             r_out_vld;
    logic [WIDTH-1:0] r_z;
    logic             r_co;
    logic             r_ovf;

    logic             w_advance;
    logic             w_take;
    logic             w_cin0;
    logic [SW-1:0]    w_s       [STAGES];
    logic             w_co      [STAGES];
    logic             w_cm      [STAGES];
    logic [WIDTH-1:0] w_sum_nxt [STAGES];

    assign w_advance = out_ready | ~r_out_vld;
    assign w_take    = in_valid & w_advance;
    assign in_ready  = w_advance;
    assign out_valid = r_out_vld;
    assign z         = r_z;
    assign carry_out = r_co;
    assign overflow  = r_ovf;

    // Effective carry into slice 0: SUB turns carry_in into a borrow, LOAD adds nothing.
    always_comb begin
        w_cin0 = carry_in;
        case (op)
            OP_SUB:  w_cin0 = ~carry_in;
            OP_LOAD: w_cin0 = 1'b0;
            default: w_cin0 = carry_in;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]    w_a;
        logic [SW-1:0]    w_b;
        logic [SW-1:0]    w_xs;
        logic [WIDTH-1:0] w_merge;

        assign w_xs = r_x[k][k*SW +: SW];

        // Operand select: ACC adds x onto the accumulator slice, LOAD passes x through (B=0, cin=0).
        always_comb begin
            w_a = w_xs;
            w_b = r_y[k][k*SW +: SW];
            case (r_op[k])
                OP_SUB:  w_b = ~r_y[k][k*SW +: SW];
                OP_ACC:  begin
                    w_a = r_acc[k*SW +: SW];
                    w_b = w_xs;
                end
                OP_LOAD: w_b = '0;
                default: w_b = r_y[k][k*SW +: SW];
            endcase
        end

        cla_slice #(
            .SLICE_WIDTH (SLICE_WIDTH),
            .GROUP_WIDTH (GROUP_WIDTH)
        ) u_slice (
            .i_a    (w_a),
            .i_b    (w_b),
            .i_cin  (r_c[k]),
            .o_sum  (w_s[k]),
            .o_cout (w_co[k]),
            .o_cmsb (w_cm[k])
        );

        // Splice this stage's slice into the partially assembled result word.
        always_comb begin
            w_merge               = r_sum[k];
            w_merge[k*SW +: SW]   = w_s[k];
        end

        assign w_sum_nxt[k] = w_merge;
    end

    // Pipeline ranks, accumulator slices and output register all move together on advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_op[k]  <= '0;
                r_x[k]   <= '0;
                r_y[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
            end
            r_acc     <= '0;
            r_out_vld <= 1'b0;
            r_z       <= '0;
            r_co      <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_advance) begin
            r_vld[0] <= w_take;
            if (w_take) begin
                r_op[0]  <= op;
                r_x[0]   <= x;
                r_y[0]   <= y;
                r_c[0]   <= w_cin0;
                r_sum[0] <= '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_op[k]  <= r_op[k-1];
                r_x[k]   <= r_x[k-1];
                r_y[k]   <= r_y[k-1];
                r_c[k]   <= w_co[k-1];
                r_sum[k] <= w_sum_nxt[k-1];
            end
            // Each slice is updated as its op passes, so a following ACC reads it one cycle later.
            for (int k = 0; k < STAGES; k++) begin
                if (r_vld[k] && ((r_op[k] == OP_ACC) || (r_op[k] == OP_LOAD))) begin
                    r_acc[k*SW +: SW] <= w_s[k];
                end
            end
            r_out_vld <= r_vld[STAGES-1];
            if (r_vld[STAGES-1]) begin
                r_z   <= w_sum_nxt[STAGES-1];
                r_co  <= w_co[STAGES-1];
                r_ovf <= w_co[STAGES-1] ^ w_cm[STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_alu.sv
// Bench for pipelined_cla_alu: directed arithmetic, ACC chaining, stall, reset flush, random stream.
// Latency: expects results STAGES=4 cycles after accept.
// Backpressure: drives out_ready low mid-stream and holds inputs while in_ready is low.
module tb_pipelined_cla_alu;
    import cla_alu_pkg::*;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        carry_in;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic        carry_out;
    logic        overflow;

    int          n_chk;
    int          n_fail;
    logic        mon_en;
    logic [17:0] got_q [$];
    logic [17:0] exp_q [$];
    logic [15:0] m_acc;
    logic [17:0] r_model;
    logic        accepted;
    logic        any_vld;
    int          n_wait;

    pipelined_cla_alu #(
        .WIDTH       (16),
        .SLICE_WIDTH (4),
        .GROUP_WIDTH (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .carry_in  (carry_in),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every result that transfers on the coming rising edge.
    always @(negedge clock) begin
        if (mon_en && out_valid && out_ready) got_q.push_back({overflow, carry_out, z});
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one op and hold it until it is accepted; returns just after the accepting edge.
    task automatic send(input logic [1:0] o, input logic c, input logic [15:0] a, input logic [15:0] b);
        int n;
        in_valid = 1'b1;
        op       = o;
        carry_in = c;
        x        = a;
        y        = b;
        n        = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("send_accept", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Single op through an empty pipeline: check latency and the result fields.
    task automatic run1(input string tag, input logic [1:0] o, input logic c, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] ez, input logic eco, input logic eovf);
        int n;
        send(o, c, a, b);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_z"}, z, ez);
        chk({tag, "_co"}, carry_out, eco);
        chk({tag, "_ovf"}, overflow, eovf);
        tick();
    endtask

    // Reference: full-width arithmetic with signed-overflow by operand/result sign rule.
    task automatic model(input logic [1:0] o, input logic c, input logic [15:0] a, input logic [15:0] b,
                         output logic [17:0] r);
        logic [16:0] s;
        logic [15:0] lhs;
        logic [15:0] rhs;
        logic        v;
        case (o)
            OP_ADD: begin lhs = a; rhs = b;  s = {1'b0, a} + {1'b0, b} + 17'(c); end
            OP_SUB: begin lhs = a; rhs = ~b; s = {1'b0, a} + {1'b0, ~b} + 17'(!c); end
            OP_ACC: begin
                lhs = m_acc; rhs = a;
                s = {1'b0, m_acc} + {1'b0, a} + 17'(c);
                m_acc = s[15:0];
            end
            default: begin lhs = a; rhs = 16'h0000; s = {1'b0, a}; m_acc = a; end
        endcase
        v = (lhs[15] == rhs[15]) && (s[15] != lhs[15]);
        r = {v, s[16], s[15:0]};
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        mon_en    = 1'b0;
        m_acc     = 16'h0000;
        reset     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        carry_in  = 1'b0;
        x         = 16'h0000;
        y         = 16'h0000;
        out_ready = 1'b1;
        accepted  = 1'b0;
        any_vld   = 1'b0;

        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_z", z, 0);
        chk("rst_co", carry_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        #2 reset = 1'b1;
        tick();

        // Directed arithmetic with hand-computed results.
        run1("add_wrap", OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run1("sub_ovf",  OP_SUB, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
        run1("add_ovf",  OP_ADD, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1);
        run1("sub_brw",  OP_SUB, 1'b1, 16'h0005, 16'h0007, 16'hFFFD, 1'b0, 1'b0);
        run1("add_mix",  OP_ADD, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0);
        run1("load_ff",  OP_LOAD, 1'b1, 16'hFFFF, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0);
        run1("acc_wrap", OP_ACC, 1'b0, 16'h0001, 16'h5555, 16'h0000, 1'b1, 1'b0);

        // LOAD then three back-to-back ACCs: each must see the previous update.
        send(OP_LOAD, 1'b0, 16'h0010, 16'h0000);
        send(OP_ACC,  1'b0, 16'h0005, 16'h0000);
        send(OP_ACC,  1'b0, 16'h0005, 16'h0000);
        send(OP_ACC,  1'b0, 16'h0005, 16'h0000);
        n_wait = 0;
        while (!out_valid && n_wait < 20) begin
            tick();
            n_wait++;
        end
        chk("chain0_vld", out_valid, 1);
        chk("chain0_z", z, 16'h0010);
        tick();
        chk("chain1_vld", out_valid, 1);
        chk("chain1_z", z, 16'h0015);
        tick();
        chk("chain2_vld", out_valid, 1);
        chk("chain2_z", z, 16'h001A);
        tick();
        chk("chain3_vld", out_valid, 1);
        chk("chain3_z", z, 16'h001F);
        tick();
        chk("chain_drained", out_valid, 0);

        // Six ADDs with a three-cycle downstream stall once results start appearing.
        got_q.delete();
        mon_en = 1'b1;
        fork
            for (int i = 0; i < 6; i++) send(OP_ADD, 1'b0, 16'(i), 16'h0100);
            begin : b_stall
                int n;
                n = 0;
                while (!out_valid && n < 20) begin
                    tick();
                    n++;
                end
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_z_hold", z, 16'h0100);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        n_wait = 0;
        while (got_q.size() < 6 && n_wait < 30) begin
            tick();
            n_wait++;
        end
        tick();
        mon_en = 1'b0;
        chk("stream_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            chk("stream_res", got_q[i], 18'h00100 + 18'(i));
        end

        // Reset with ops in flight: outputs clear at once and nothing reappears.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(OP_ADD, 1'b0, 16'(i), 16'h0001);
        n_wait = 0;
        while (!out_valid && n_wait < 20) begin
            tick();
            n_wait++;
        end
        chk("pre_rst_vld", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_vld", out_valid, 0);
        chk("rst_async_z", z, 0);
        #2 reset = 1'b1;
        out_ready = 1'b1;
        any_vld = 1'b0;
        repeat (6) begin
            tick();
            if (out_valid) any_vld = 1'b1;
        end
        chk("rst_flushed", any_vld, 0);
        run1("acc_after_rst", OP_ACC, 1'b0, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0);
        m_acc = 16'h0001;

        // Random ops with random in_valid/out_ready against the reference model.
        got_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    op       = 2'($urandom_range(0, 3));
                    carry_in = 1'($urandom_range(0, 1));
                    x        = 16'($urandom);
                    y        = 16'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            accepted = in_valid && in_ready;
            if (accepted) begin
                model(op, carry_in, x, y, r_model);
                exp_q.push_back(r_model);
            end
            @(posedge clock);
            #1;
            if (accepted) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_wait = 0;
        while (got_q.size() < exp_q.size() && n_wait < 50) begin
            tick();
            n_wait++;
        end
        mon_en = 1'b0;
        chk("rand_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("rand_res", got_q[i], exp_q[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
